// File: rtl/core_seq_unit_if.sv
// Sequencer bus: opcode/immediate/flags in, IP and return-stack status out.
// Interrupt signals are present even when the interrupt feature is compiled out.
interface core_seq_unit_if #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned OPC_W    = 5,
    parameter int unsigned RS_DEPTH = 8
);
    localparam int unsigned SP_W = $clog2(RS_DEPTH) + 1;

    logic [OPC_W-1:0]  OPC;
    logic [ADDR_W-1:0] IMM;
    logic              BUSY;
    logic              FL_ZF;
    logic              FL_CF;
    logic              INT_REQ;
    logic [3:0]        INT_NUM;

    logic [ADDR_W-1:0] IP;
    logic              FLAG_RESTORE;
    logic              FL_ZF_R;
    logic              FL_CF_R;
    logic [SP_W-1:0]   SP;
    logic              STACK_FAULT;
    logic              HALTED;
    logic              INT_ACK;
    logic              IN_ISR;

    modport master (
        input  OPC, IMM, BUSY, FL_ZF, FL_CF, INT_REQ, INT_NUM,
        output IP, FLAG_RESTORE, FL_ZF_R, FL_CF_R, SP, STACK_FAULT, HALTED, INT_ACK, IN_ISR
    );

    modport slave (
        output OPC, IMM, BUSY, FL_ZF, FL_CF, INT_REQ, INT_NUM,
        input  IP, FLAG_RESTORE, FL_ZF_R, FL_CF_R, SP, STACK_FAULT, HALTED, INT_ACK, IN_ISR
    );
endinterface

// File: rtl/core_seq_unit.sv
// MicroCPU instruction sequencer: IP, branches, CALL/RET return stack, HALT and FAULT states.
// Define CORE_SEQ_INT_EN to enable hardware interrupt vectoring and RETI.
module core_seq_unit #(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned OPC_W        = 5,
    parameter int unsigned RS_DEPTH     = 8,
    parameter int unsigned INT_VEC_BASE = 'hF0
) (
    input  logic           CLK,
    input  logic           RESET,
    core_seq_unit_if.master bus
);
    localparam int unsigned PTR_W = $clog2(RS_DEPTH);
    localparam int unsigned SP_W  = PTR_W + 1;

    localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_BREQ = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_BRNE = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_BRCS = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_BRCC = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_CALL = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_RET  = OPC_W'(7);
    localparam logic [OPC_W-1:0] OP_RETI = OPC_W'(8);
    localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(9);

    typedef enum logic [1:0] {S_RUN, S_HALT, S_FAULT} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] ip;
        logic              zf;
        logic              cf;
    } rs_entry_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] ip_q, ip_n, ip_inc, int_vec;
    logic [SP_W-1:0]   sp_q, sp_n, sp_dec;
    logic              fault_q, fault_n;
    logic              frestore_q, frestore_n;
    logic              zf_r_q, zf_r_n, cf_r_q, cf_r_n;
    logic              ack_q, ack_n;
    logic              in_isr_q, in_isr_n;
    logic              halted_q;
    logic              sp_full, sp_empty, int_take;
    logic              push;
    rs_entry_t         push_data, top;
    rs_entry_t         stack [RS_DEPTH];

    assign ip_inc   = ip_q + ADDR_W'(1);
    assign sp_dec   = sp_q - SP_W'(1);
    assign sp_full  = (sp_q == SP_W'(RS_DEPTH));
    assign sp_empty = (sp_q == '0);
    assign top      = stack[sp_dec[PTR_W-1:0]];
    assign int_vec  = ADDR_W'(INT_VEC_BASE) + ADDR_W'(bus.INT_NUM);

`ifdef CORE_SEQ_INT_EN
    // Interrupts are masked while in service and deferred (not faulted) on a full stack.
    assign int_take = bus.INT_REQ && !in_isr_q && !sp_full;
`else
    logic unused_int_req;
    assign unused_int_req = bus.INT_REQ;
    assign int_take       = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= S_RUN;
        else        state <= state_n;
    end

    // Next-state, next-IP and return-stack control
    always_comb begin
        state_n    = state;
        ip_n       = ip_q;
        sp_n       = sp_q;
        fault_n    = fault_q;
        frestore_n = 1'b0;
        zf_r_n     = zf_r_q;
        cf_r_n     = cf_r_q;
        ack_n      = 1'b0;
        in_isr_n   = in_isr_q;
        push       = 1'b0;
        push_data  = '{ip: ip_inc, zf: bus.FL_ZF, cf: bus.FL_CF};

        case (state)
            S_RUN: begin
                if (bus.BUSY) begin
                    state_n = S_RUN;
                end else if (int_take) begin
                    // The instruction at IP is pre-empted, so it is the return address.
                    push         = 1'b1;
                    push_data.ip = ip_q;
                    sp_n         = sp_q + SP_W'(1);
                    ip_n         = int_vec;
                    ack_n        = 1'b1;
                    in_isr_n     = 1'b1;
                end else begin
                    ip_n = ip_inc;
                    case (bus.OPC)
                        OP_JMP:  ip_n = bus.IMM;
                        OP_BREQ: if (bus.FL_ZF)  ip_n = bus.IMM;
                        OP_BRNE: if (!bus.FL_ZF) ip_n = bus.IMM;
                        OP_BRCS: if (bus.FL_CF)  ip_n = bus.IMM;
                        OP_BRCC: if (!bus.FL_CF) ip_n = bus.IMM;
                        OP_CALL: begin
                            if (sp_full) begin
                                ip_n    = ip_q;
                                fault_n = 1'b1;
                                state_n = S_FAULT;
                            end else begin
                                push = 1'b1;
                                sp_n = sp_q + SP_W'(1);
                                ip_n = bus.IMM;
                            end
                        end
                        OP_RET, OP_RETI: begin
                            if (sp_empty) begin
                                ip_n    = ip_q;
                                fault_n = 1'b1;
                                state_n = S_FAULT;
                            end else begin
                                ip_n       = top.ip;
                                sp_n       = sp_dec;
                                frestore_n = 1'b1;
                                zf_r_n     = top.zf;
                                cf_r_n     = top.cf;
`ifdef CORE_SEQ_INT_EN
                                if (bus.OPC == OP_RETI) in_isr_n = 1'b0;
`endif
                            end
                        end
                        OP_HALT: begin
                            ip_n    = ip_q;
                            state_n = S_HALT;
                        end
                        default: ip_n = ip_inc;
                    endcase
                end
            end
            S_HALT: begin
                // Waking from HALT returns past the HALT instruction.
                if (int_take) begin
                    push     = 1'b1;
                    sp_n     = sp_q + SP_W'(1);
                    ip_n     = int_vec;
                    ack_n    = 1'b1;
                    in_isr_n = 1'b1;
                    state_n  = S_RUN;
                end
            end
            S_FAULT: state_n = S_FAULT;
            default: state_n = S_RUN;
        endcase
    end

    // Registered outputs
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ip_q       <= '0;
            sp_q       <= '0;
            fault_q    <= 1'b0;
            frestore_q <= 1'b0;
            zf_r_q     <= 1'b0;
            cf_r_q     <= 1'b0;
            ack_q      <= 1'b0;
            in_isr_q   <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            ip_q       <= ip_n;
            sp_q       <= sp_n;
            fault_q    <= fault_n;
            frestore_q <= frestore_n;
            zf_r_q     <= zf_r_n;
            cf_r_q     <= cf_r_n;
            ack_q      <= ack_n;
            in_isr_q   <= in_isr_n;
            halted_q   <= (state_n == S_HALT);
        end
    end

    // Return-stack storage; contents are don't-care after reset
    always_ff @(posedge CLK) begin
        if (push) stack[sp_q[PTR_W-1:0]] <= push_data;
    end

    assign bus.IP           = ip_q;
    assign bus.SP           = sp_q;
    assign bus.STACK_FAULT  = fault_q;
    assign bus.FLAG_RESTORE = frestore_q;
    assign bus.FL_ZF_R      = zf_r_q;
    assign bus.FL_CF_R      = cf_r_q;
    assign bus.HALTED       = halted_q;
    assign bus.INT_ACK      = ack_q;
    assign bus.IN_ISR       = in_isr_q;
endmodule
